// File: rtl/qam_pkg.sv
// QAM serial-to-parallel mapper shared definitions.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   out_state_t    - output stage occupancy (EMPTY / ONE / TWO)
//   MAX_K          - widest supported axis (BITS_PER_SYM = 8 -> 4 bits per axis)
//   calc_level_w() - signed level width for a given BITS_PER_SYM
//   gray2bin()     - Gray -> binary on a MAX_K-bit word; zero-extended Gray
//                    codes convert to zero-extended binary, so narrower axes
//                    simply pad with zeros on the left.
package qam_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } out_state_t;

  localparam int MAX_K = 4;

  function automatic int calc_level_w(input int bits_per_sym);
    return bits_per_sym / 2 + 1;
  endfunction

  function automatic logic [MAX_K-1:0] gray2bin(input logic [MAX_K-1:0] g);
    logic [MAX_K-1:0] b;
    b[MAX_K-1] = g[MAX_K-1];
    for (int i = MAX_K - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/qam_gray_level.sv
// Converts one K-bit Gray-coded axis value into a signed QAM level.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of the input).
//
// Ports:
//   i_gray  [K-1:0]  Gray-coded axis bits
//   o_level [K:0]    two's-complement level 2*b - (2^K - 1)
module qam_gray_level
  import qam_pkg::*;
#(
  parameter  int K       = 2,
  localparam int LEVEL_W = K + 1
) (
  input  logic [K-1:0]       i_gray,
  output logic [LEVEL_W-1:0] o_level
);

  // Offset that centres the constellation: levels run -(2^K-1) .. +(2^K-1).
  localparam int OFFSET = (1 << K) - 1;

  logic [MAX_K-1:0] w_gray_ext;
  logic [MAX_K-1:0] w_bin;
  logic [MAX_K+1:0] w_twice;
  logic [MAX_K+1:0] w_offset;
  logic [MAX_K+1:0] w_level_ext;
  logic             w_unused_hi;

  always_comb begin
    w_gray_ext         = '0;
    w_gray_ext[K-1:0]  = i_gray;
  end

  assign w_bin       = gray2bin(w_gray_ext);
  assign w_twice     = {1'b0, w_bin, 1'b0};
  assign w_offset    = OFFSET[MAX_K+1:0];
  assign w_level_ext = w_twice - w_offset;

  // The result always fits in LEVEL_W bits; the upper bits are sign copies.
  assign o_level     = w_level_ext[LEVEL_W-1:0];
  assign w_unused_hi = ^w_level_ext[MAX_K+1:LEVEL_W];

endmodule

// File: rtl/qam_s2p_mapper.sv
// Serial-to-parallel QAM mapper: assembles BITS_PER_SYM strobed bits into a
// Gray-coded symbol and emits signed I/Q levels.
// Latency: sym_valid rises the cycle after the completing strobe (empty output).
// Backpressure: valid/ready; output register plus one-deep pending buffer,
// a symbol completing while both are full is dropped and overrun is set.
//
// Ports:
//   clock, reset      clock, asynchronous active-high reset
//   adat_be_S         serial data bit, sampled when data_change=1
//   data_change       bit strobe, one bit per high cycle, never stalled
//   sym_ready         downstream accepts the current symbol
//   sym_valid         sym_i/sym_q hold a valid symbol
//   sym_i, sym_q      signed in-phase / quadrature levels
//   elojel_sin_cos    {sign(sym_i), sign(sym_q)}, 1 = negative
//   overrun           sticky, set when a completed symbol is dropped
module qam_s2p_mapper
  import qam_pkg::*;
#(
  parameter  int BITS_PER_SYM = 4,
  localparam int K            = BITS_PER_SYM / 2,
  localparam int LEVEL_W      = calc_level_w(BITS_PER_SYM)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               adat_be_S,
  input  logic               data_change,
  input  logic               sym_ready,
  output logic               sym_valid,
  output logic [LEVEL_W-1:0] sym_i,
  output logic [LEVEL_W-1:0] sym_q,
  output logic [1:0]         elojel_sin_cos,
  output logic               overrun
);

  localparam logic [2:0] LAST_CNT = 3'(BITS_PER_SYM - 1);

  // Assembly holds only the bits already received; the word being completed
  // is formed combinationally with the incoming bit as its LSB.
  logic [BITS_PER_SYM-2:0] r_shift;
  logic [2:0]              r_cnt;
  logic [BITS_PER_SYM-1:0] w_word;
  logic                    w_complete;

  logic [LEVEL_W-1:0]      w_new_i;
  logic [LEVEL_W-1:0]      w_new_q;

  out_state_t              r_state;
  logic [LEVEL_W-1:0]      r_out_i;
  logic [LEVEL_W-1:0]      r_out_q;
  logic [LEVEL_W-1:0]      r_pend_i;
  logic [LEVEL_W-1:0]      r_pend_q;
  logic                    r_overrun;
  logic                    w_xfer;

  assign w_word     = {r_shift, adat_be_S};
  assign w_complete = data_change && (r_cnt == LAST_CNT);

  // Bit assembly: runs on every strobe regardless of output occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (data_change) begin
      r_shift <= w_word[BITS_PER_SYM-2:0];
      r_cnt   <= w_complete ? 3'd0 : r_cnt + 3'd1;
    end
  end

  qam_gray_level #(.K(K)) u_level_i (
    .i_gray  (w_word[BITS_PER_SYM-1:K]),
    .o_level (w_new_i)
  );

  qam_gray_level #(.K(K)) u_level_q (
    .i_gray  (w_word[K-1:0]),
    .o_level (w_new_q)
  );

  assign w_xfer = (r_state != EMPTY) && sym_ready;

  // Output stage occupancy. The pending buffer is only meaningful in TWO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= EMPTY;
      r_out_i   <= '0;
      r_out_q   <= '0;
      r_pend_i  <= '0;
      r_pend_q  <= '0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_complete) begin
            r_out_i <= w_new_i;
            r_out_q <= w_new_q;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_xfer && w_complete) begin
            r_out_i <= w_new_i;
            r_out_q <= w_new_q;
          end else if (w_xfer) begin
            r_state <= EMPTY;
          end else if (w_complete) begin
            r_pend_i <= w_new_i;
            r_pend_q <= w_new_q;
            r_state  <= TWO;
          end
        end
        TWO: begin
          if (w_xfer) begin
            r_out_i <= r_pend_i;
            r_out_q <= r_pend_q;
            if (w_complete) begin
              // Pending slot frees up this cycle, so the new symbol fits.
              r_pend_i <= w_new_i;
              r_pend_q <= w_new_q;
            end else begin
              r_state <= ONE;
            end
          end else if (w_complete) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign sym_valid      = (r_state != EMPTY);
  assign sym_i          = r_out_i;
  assign sym_q          = r_out_q;
  assign elojel_sin_cos = {r_out_i[LEVEL_W-1], r_out_q[LEVEL_W-1]};
  assign overrun        = r_overrun;

endmodule

// File: doc/qam_s2p_mapper.md
QAM_S2P_MAPPER -- requirements
Module: qam_s2p_mapper

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock port SHALL be named clock and the reset port reset.
REQ-002 Parameter BITS_PER_SYM, default 4: bits per QAM symbol; legal values are even, 2..8.
REQ-003 Derived constants: K = BITS_PER_SYM/2 bits per axis; LEVEL_W = K+1 signed bits per level.
REQ-004 clock  in  1  system clock, all state updates on rising edge.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 adat_be_S  in  1  serial data bit, sampled only when data_change=1.
REQ-007 data_change  in  1  bit strobe; one serial bit accepted per high cycle.
REQ-008 sym_ready  in  1  downstream accepts the symbol this cycle.
REQ-009 sym_valid  out  1  sym_i/sym_q hold a valid symbol.
REQ-010 sym_i  out  LEVEL_W  signed in-phase (cos) level.
REQ-011 sym_q  out  LEVEL_W  signed quadrature (sin) level.
REQ-012 elojel_sin_cos  out  2  sign bits {sign(sym_i), sign(sym_q)}, 1 = negative.
REQ-013 overrun  out  1  sticky flag, symbol dropped due to backpressure.

Function
REQ-014 Each strobed bit SHALL shift into an assembly register MSB-first; a bit counter (0..BITS_PER_SYM-1) SHALL count strobes.
REQ-015 On the strobe that delivers bit BITS_PER_SYM, the word SHALL complete and the counter SHALL wrap to 0 in the same cycle.
REQ-016 Of the completed word, upper K bits SHALL form the I Gray code and lower K bits the Q Gray code.
REQ-017 Each axis SHALL be converted Gray->binary b, then level = 2*b - (2^K - 1); K=2 gives Gray 00,01,11,10 -> -3,-1,+1,+3.
REQ-018 Latency: sym_valid SHALL rise on the cycle after the completing strobe when the output register is empty.
REQ-019 A transfer SHALL occur on every cycle with sym_valid=1 and sym_ready=1; sym_i/sym_q SHALL stay stable while sym_valid=1 and sym_ready=0.
REQ-020 The output stage SHALL be a 3-state machine: EMPTY (no symbol), ONE (output register full), TWO (output full plus one-deep pending buffer full).
REQ-021 EMPTY: completion -> ONE.
REQ-022 ONE: completion without transfer -> TWO; transfer without completion -> EMPTY; transfer with completion -> ONE with the new symbol.
REQ-023 TWO: transfer -> ONE with the pending symbol moved to the output; a completion in the same cycle SHALL be written to pending (stay TWO).
REQ-024 TWO: completion without transfer SHALL drop the new symbol, stay TWO, and set overrun.
REQ-025 overrun SHALL be cleared only by reset.
REQ-026 elojel_sin_cos SHALL equal {sym_i[LEVEL_W-1], sym_q[LEVEL_W-1]} at all times.
REQ-027 A data_change strobe SHALL never be lost or stalled; backpressure affects completed symbols only.

Reset
REQ-028 Reset SHALL force sym_valid=0, sym_i=0, sym_q=0, elojel_sin_cos=2'b00, overrun=0, state EMPTY, bit counter 0, assembly and pending registers 0.
REQ-029 Reset mid-symbol SHALL discard partial bits; assembly restarts at bit 1 after release.

Structure
REQ-030 Shared package qam_pkg SHALL hold the state enum (EMPTY/ONE/TWO), the LEVEL_W computation and the Gray->binary function.
REQ-031 Sub-module qam_gray_level (combinational, K-bit Gray -> LEVEL_W signed level) SHALL be instantiated once per axis.

Verification
REQ-032 BITS_PER_SYM=4, sym_ready=1, strobe bits 1,0,0,1 -> one cycle after 4th strobe sym_valid=1, sym_i=+3, sym_q=-1, elojel_sin_cos=2'b01.
REQ-033 BITS_PER_SYM=2, bits 0,1 -> sym_i=-1, sym_q=+1, elojel_sin_cos=2'b10.
REQ-034 sym_ready=0, three symbols 0000, 0101, 1111 -> output holds 0000 (-3,-3), 1111 is dropped, overrun=1; then sym_ready=1 -> two transfers (-3,-3), (-1,-1), then sym_valid=0, overrun stays 1.
REQ-035 State TWO, sym_ready=1 in the same cycle a new symbol completes -> no drop, overrun=0, three symbols delivered in order.
REQ-036 Two bits strobed, reset pulsed, then bits 1,1,1,0 -> single symbol sym_i=+1, sym_q=+3.
REQ-037 BITS_PER_SYM=6, bits 100,000 -> sym_i=+7, sym_q=-7.
